// File: rtl/operand_gather_seq.sv
// operand_gather_seq: 8-slot operand bank that feeds an external 8:1 word mux.
// It walks sel over slots 0..count-1 and captures each mux result into a
// valid/ready output register.
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   wr_en/wr_addr/wr_data     slot write; sets the slot valid bit
//   clr                       clears all slot valid bits (data kept)
//   start/count               sequence request, sampled in IDLE only
//   busy, slot_valid          status
//   sel, d / mux_q            interface to the external mux
//   out_valid/out_ready/
//   out_data/out_idx          output word handshake
//   done                      one-cycle pulse when the final word is taken
module operand_gather_seq #(
    parameter int RV_BIT_NUM = 32,
    parameter int NUM_SLOTS  = 8,
    parameter int SEL_WIDTH  = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [SEL_WIDTH-1:0]             wr_addr,
    input  logic [RV_BIT_NUM-1:0]            wr_data,
    input  logic                             clr,
    input  logic                             start,
    input  logic [3:0]                       count,
    output logic                             busy,
    output logic [NUM_SLOTS-1:0]             slot_valid,
    output logic [SEL_WIDTH-1:0]             sel,
    output logic [RV_BIT_NUM*NUM_SLOTS-1:0]  d,
    input  logic [RV_BIT_NUM-1:0]            mux_q,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [RV_BIT_NUM-1:0]            out_data,
    output logic [SEL_WIDTH-1:0]             out_idx,
    output logic                             done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0]           MAX_CNT  = 4'(NUM_SLOTS);
    localparam logic [SEL_WIDTH-1:0] LAST_MAX = SEL_WIDTH'(NUM_SLOTS - 1);

    state_t                  state_q, state_d;
    logic [SEL_WIDTH-1:0]    idx_q, idx_d;
    logic [SEL_WIDTH-1:0]    last_q, last_d;
    logic [NUM_SLOTS-1:0]    valid_q, valid_d;
    logic                    out_valid_q, out_valid_d;
    logic [RV_BIT_NUM-1:0]   out_data_q, out_data_d;
    logic [SEL_WIDTH-1:0]    out_idx_q, out_idx_d;
    logic                    done_q, done_d;
    logic [RV_BIT_NUM-1:0]   slot_q [NUM_SLOTS];

    logic                    issue;
    logic                    accept;
    logic [3:0]              cnt_m1;

    // A new word may be captured when the output register is empty or
    // is being emptied in the same cycle.
    assign issue  = (state_q == S_RUN) && valid_q[idx_q] &&
                    (!out_valid_q || out_ready);
    assign accept = out_valid_q && out_ready;
    assign cnt_m1 = count - 4'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        valid_d     = valid_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        done_d      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start && (count != 4'd0)) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    last_d  = (count > MAX_CNT) ? LAST_MAX
                                                : cnt_m1[SEL_WIDTH-1:0];
                end
            end
            S_RUN: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                end
                if (issue) begin
                    out_valid_d    = 1'b1;
                    out_data_d     = mux_q;
                    out_idx_d      = idx_q;
                    valid_d[idx_q] = 1'b0;
                    if (idx_q == last_q) begin
                        state_d = S_DRAIN;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                    idx_d       = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        // Clear first, then a same-cycle write sets its slot; a write
        // also overrides the consume of a slot issuing this cycle.
        if (clr) begin
            valid_d = '0;
        end
        if (wr_en) begin
            valid_d[wr_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            valid_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            valid_q     <= valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            done_q      <= done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_q[k] <= '0;
            end
        end else if (wr_en) begin
            slot_q[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_d
        assign d[k*RV_BIT_NUM +: RV_BIT_NUM] = slot_q[k];
    end

    assign busy       = (state_q != S_IDLE);
    assign slot_valid = valid_q;
    assign sel        = idx_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_idx    = out_idx_q;
    assign done       = done_q;

endmodule

// File: tb/tb_operand_gather_seq.sv
// Testbench for operand_gather_seq: random operands, an 8:1 mux model and
// a reference of the expected word stream and slot valid bits.
module tb_operand_gather_seq;
    localparam int W = 32;
    localparam int N = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [2:0]       wr_addr;
    logic [W-1:0]     wr_data;
    logic             clr;
    logic             start;
    logic [3:0]       count;
    logic             busy;
    logic [N-1:0]     slot_valid;
    logic [2:0]       sel;
    logic [W*N-1:0]   d;
    logic [W-1:0]     mux_q;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [2:0]       out_idx;
    logic             done;

    operand_gather_seq #(.RV_BIT_NUM(W), .NUM_SLOTS(N), .SEL_WIDTH(3)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .clr(clr), .start(start), .count(count),
        .busy(busy), .slot_valid(slot_valid), .sel(sel), .d(d),
        .mux_q(mux_q), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .done(done)
    );

    // External 8:1 word mux
    assign mux_q = d[sel*W +: W];

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   idx;
        logic [W-1:0] data;
    } word_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mem [N];
    logic [N-1:0] mvld;
    word_t        acc [$];
    int           done_cnt = 0;
    bit           prev_done = 1'b0;

    // Record every word the consumer takes, and watch the done pulse width.
    always @(negedge clk) begin
        word_t w;
        if (!rst && out_valid && out_ready) begin
            w.idx  = out_idx;
            w.data = out_data;
            acc.push_back(w);
        end
        if (done) begin
            done_cnt++;
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width got=2+ cycles exp=1 cycle");
            end
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [W-1:0] v);
        wr_en = 1'b1; wr_addr = a; wr_data = v;
        tick();
        wr_en = 1'b0;
        mem[a] = v;
        mvld[a] = 1'b1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mvld = '0;
    endtask

    task automatic load_all_random();
        for (int k = 0; k < N; k++) wr(3'(k), $urandom());
    endtask

    task automatic start_seq(input logic [3:0] c);
        start = 1'b1; count = c;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(input int budget, input bit rnd,
                                  output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks += 8;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        if (slot_valid !== 8'h00) begin errors++; $display("FAIL reset_slot_valid got=%h exp=00", slot_valid); end
        if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
        if (d !== '0) begin errors++; $display("FAIL reset_d got=%h exp=0", d); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
        if (out_idx !== 3'd0) begin errors++; $display("FAIL reset_out_idx got=%0d exp=0", out_idx); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        rst = 1'b0;
        for (int k = 0; k < N; k++) mem[k] = '0;
        mvld = '0;
        tick();
    endtask

    task automatic test_full_seq();
        logic [W*N-1:0] exp_d;
        do_clr();
        for (int k = 0; k < N; k++) wr(3'(k), 32'h1000_0000 | W'(k));
        for (int k = 0; k < N; k++) exp_d[k*W +: W] = mem[k];
        checks++;
        if (d !== exp_d) begin errors++; $display("FAIL full_d got=%h exp=%h", d, exp_d); end
        out_ready = 1'b1;
        start_seq(4'd8);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL full_latency1 got valid=%0b busy=%0b exp valid=0 busy=1", out_valid, busy);
        end
        tick();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'(k) || out_data !== mem[k]) begin
                errors++;
                $display("FAIL full_word%0d got v=%0b idx=%0d data=%h exp v=1 idx=%0d data=%h",
                         k, out_valid, out_idx, out_data, k, mem[k]);
            end
            tick();
        end
        mvld = '0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || slot_valid !== mvld) begin
            errors++;
            $display("FAIL full_end got done=%0b busy=%0b v=%0b sv=%h exp 1 0 0 %h",
                     done, busy, out_valid, slot_valid, mvld);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL full_done_pulse got=%0b exp=0", done); end
    endtask

    task automatic test_stall();
        bit ok;
        do_clr();
        acc.delete();
        wr(3'd0, $urandom());
        wr(3'd1, $urandom());
        out_ready = 1'b1;
        start_seq(4'd4);
        repeat (8) tick();
        checks++;
        if (acc.size() != 2 || sel !== 3'd2 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got words=%0d sel=%0d busy=%0b v=%0b exp 2 2 1 0",
                     acc.size(), sel, busy, out_valid);
        end
        wr(3'd2, $urandom());
        repeat (3) tick();
        wr(3'd3, $urandom());
        run_until_done(50, 1'b0, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stall_timeout got=no done exp=done"); end
        checks++;
        if (acc.size() != 4) begin
            errors++;
            $display("FAIL stall_count got=%0d exp=4", acc.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (acc[i].idx !== 3'(i) || acc[i].data !== mem[i]) begin
                    errors++;
                    $display("FAIL stall_word%0d got idx=%0d data=%h exp idx=%0d data=%h",
                             i, acc[i].idx, acc[i].data, i, mem[i]);
                end
            end
        end
        mvld[3:0] = '0;
        checks++;
        if (slot_valid !== mvld) begin errors++; $display("FAIL stall_sv got=%h exp=%h", slot_valid, mvld); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit seen;
        do_clr();
        load_all_random();
        acc.delete();
        out_ready = 1'b0;
        start_seq(4'd8);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL bp_first_timeout got=no word exp=word"); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_idx !== 3'd0 || out_data !== mem[0]) begin
                errors++;
                $display("FAIL bp_stable%0d got v=%0b idx=%0d data=%h exp v=1 idx=0 data=%h",
                         i, out_valid, out_idx, out_data, mem[0]);
            end
            tick();
        end
        checks++;
        if (slot_valid !== 8'hFE) begin errors++; $display("FAIL bp_sv got=%h exp=fe", slot_valid); end
        run_until_done(300, 1'b1, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_timeout got=no done exp=done"); end
        checks++;
        if (acc.size() != 8) begin
            errors++;
            $display("FAIL bp_count got=%0d exp=8", acc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (acc[i].idx !== 3'(i) || acc[i].data !== mem[i]) begin
                    errors++;
                    $display("FAIL bp_word%0d got idx=%0d data=%h exp idx=%0d data=%h",
                             i, acc[i].idx, acc[i].data, i, mem[i]);
                end
            end
        end
        mvld = '0;
        checks++;
        if (slot_valid !== mvld) begin errors++; $display("FAIL bp_sv_end got=%h exp=%h", slot_valid, mvld); end
    endtask

    task automatic test_count_edges();
        bit ok;
        do_clr();
        load_all_random();
        out_ready = 1'b1;
        start_seq(4'd0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL cnt0_busy got=%0b exp=0", busy); end
            tick();
        end
        acc.delete();
        start_seq(4'd12);
        tick();
        // start while busy must be ignored
        start_seq(4'd3);
        run_until_done(50, 1'b0, ok);
        repeat (4) tick();
        checks++;
        if (!ok || busy !== 1'b0) begin
            errors++;
            $display("FAIL cnt12_end got done=%0b busy=%0b exp done=1 busy=0", ok, busy);
        end
        checks++;
        if (acc.size() != 8) begin
            errors++;
            $display("FAIL cnt12_count got=%0d exp=8", acc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (acc[i].idx !== 3'(i) || acc[i].data !== mem[i]) begin
                    errors++;
                    $display("FAIL cnt12_word%0d got idx=%0d data=%h exp idx=%0d data=%h",
                             i, acc[i].idx, acc[i].data, i, mem[i]);
                end
            end
        end
        mvld = '0;
        checks++;
        if (slot_valid !== mvld) begin errors++; $display("FAIL cnt12_sv got=%h exp=%h", slot_valid, mvld); end
    endtask

    task automatic test_random_seq();
        bit ok;
        int c;
        int n;
        for (int r = 0; r < 6; r++) begin
            do_clr();
            load_all_random();
            acc.delete();
            c = $urandom_range(1, 15);
            n = (c > 8) ? 8 : c;
            start_seq(4'(c));
            run_until_done(300, 1'b1, ok);
            checks++;
            if (!ok) begin errors++; $display("FAIL rnd%0d_timeout got=no done exp=done", r); end
            checks++;
            if (acc.size() != n) begin
                errors++;
                $display("FAIL rnd%0d_count got=%0d exp=%0d", r, acc.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    if (acc[i].idx !== 3'(i) || acc[i].data !== mem[i]) begin
                        errors++;
                        $display("FAIL rnd%0d_word%0d got idx=%0d data=%h exp idx=%0d data=%h",
                                 r, i, acc[i].idx, acc[i].data, i, mem[i]);
                    end
                end
            end
            for (int i = 0; i < n; i++) mvld[i] = 1'b0;
            checks++;
            if (slot_valid !== mvld) begin errors++; $display("FAIL rnd%0d_sv got=%h exp=%h", r, slot_valid, mvld); end
        end
    endtask

    task automatic test_collision();
        bit ok;
        bit seen;
        logic [W-1:0] nv;
        do_clr();
        for (int k = 0; k < N; k++) wr(3'(k), W'(k));
        acc.delete();
        out_ready = 1'b1;
        start_seq(4'd8);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sel == 3'd3) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL col_sel3 got=never exp=sel 3"); end
        wr(3'd3, 32'hDEAD_BEEF);
        run_until_done(50, 1'b0, ok);
        checks++;
        if (!ok || acc.size() != 8) begin
            errors++;
            $display("FAIL col_count got done=%0b words=%0d exp done=1 words=8", ok, acc.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (acc[i].idx !== 3'(i) || acc[i].data !== W'(i)) begin
                    errors++;
                    $display("FAIL col_word%0d got idx=%0d data=%h exp idx=%0d data=%h",
                             i, acc[i].idx, acc[i].data, i, W'(i));
                end
            end
        end
        checks++;
        if (slot_valid !== 8'h08 || d[3*W +: W] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL col_slot3 got sv=%h d3=%h exp sv=08 d3=deadbeef", slot_valid, d[3*W +: W]);
        end
        // clr and write together: clear wins everywhere but the written slot
        nv = $urandom();
        clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd5; wr_data = nv;
        #1;
        checks++;
        if (slot_valid !== 8'h08) begin errors++; $display("FAIL col_vis_early got=%h exp=08", slot_valid); end
        tick();
        clr = 1'b0; wr_en = 1'b0;
        mem[5] = nv;
        mvld = 8'h20;
        checks++;
        if (slot_valid !== mvld || d[5*W +: W] !== nv) begin
            errors++;
            $display("FAIL col_clr_wr got sv=%h d5=%h exp sv=%h d5=%h", slot_valid, d[5*W +: W], mvld, nv);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        int dc;
        do_clr();
        load_all_random();
        out_ready = 1'b1;
        start_seq(4'd8);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (sel == 3'd4) begin seen = 1'b1; break; end
            tick();
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rmid_sel4 got=never exp=sel 4"); end
        dc = done_cnt;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || out_idx !== 3'd0 ||
            sel !== 3'd0 || slot_valid !== 8'h00 || d !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rmid_outputs got busy=%0b v=%0b data=%h idx=%0d sel=%0d sv=%h done=%0b exp all 0",
                     busy, out_valid, out_data, out_idx, sel, slot_valid, done);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got busy=%0b exp=0", busy); end
            tick();
        end
        checks++;
        if (done_cnt != dc) begin errors++; $display("FAIL rmid_done got=%0d pulses exp=0", done_cnt - dc); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        clr = 1'b0; start = 1'b0; count = '0; out_ready = 1'b0;
        test_reset();
        test_full_seq();
        test_stall();
        test_backpressure();
        test_count_edges();
        test_random_seq();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
